// File: rtl/multi_clock_gate.sv
// multi_clock_gate: N-channel glitch-free clock gate with per-channel turn-off
// hysteresis and a DFT force-on override.
module multi_clock_gate #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] enable,
  input  logic            test_en,
  output logic [N_CH-1:0] gated_clk,
  output logic [N_CH-1:0] ch_on,
  output logic            all_off
);

  localparam longint unsigned CNT_MAX     = (64'd1 << CNT_W) - 64'd1;
  localparam int unsigned     HOLD_LOAD_I = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_LOAD_I);

  // Reject parameter sets the hold counter or channel vector cannot represent.
  if (longint'(IDLE_CYCLES) > CNT_MAX) begin : g_bad_idle
    $error("multi_clock_gate: IDLE_CYCLES does not fit in CNT_W bits");
  end
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("multi_clock_gate: N_CH must be in 1..32");
  end

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [N_CH-1:0] en_q;
  logic [N_CH-1:0] gate_n;
  logic            test_en_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Per-channel request FSM with turn-off hold counter.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= ST_OFF;
        cnt   <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            if (enable[i]) state <= ST_ON;
          end
          ST_ON: begin
            if (!enable[i]) begin
              if (IDLE_CYCLES == 0) begin
                state <= ST_OFF;
              end else begin
                state <= ST_HOLD;
                cnt   <= HOLD_LOAD;
              end
            end
          end
          ST_HOLD: begin
            if (enable[i])          state <= ST_ON;
            else if (cnt != '0)     cnt   <= cnt - CNT_W'(1);
            else                    state <= ST_OFF;
          end
          default: state <= ST_OFF;
        endcase
      end
    end

    // Posedge-stage enable: branch wanted for the next clock period.
    assign en_q[i] = (state != ST_OFF);
  end

  // Posedge capture of the DFT override so it shares the FSM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) test_en_q <= 1'b0;
    else        test_en_q <= test_en;
  end

  // Low-phase latch stage: gate only moves while clk is low, so no glitches.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) gate_n <= '0;
    else        gate_n <= en_q | {N_CH{test_en_q}};
  end

  assign gated_clk = {N_CH{clk}} & gate_n;
  assign ch_on     = gate_n;
  assign all_off   = ~|gate_n;

endmodule

// File: tb/tb_multi_clock_gate.sv
// Bench for multi_clock_gate: two builds (IDLE_CYCLES=8 and 0) driven with the
// same stimulus and checked against a "last enable sample" window model.
module tb_multi_clock_gate;

  localparam int unsigned N      = 4;
  localparam int          IDLE_A = 8;
  localparam int          IDLE_B = 0;

  logic         clk;
  logic         reset;
  logic [N-1:0] enable;
  logic         test_en;
  logic [N-1:0] gated_a, ch_on_a, gated_b, ch_on_b;
  logic         all_off_a, all_off_b;

  int   vectors;
  int   errors;
  int   p;
  int   last_hi [N];
  logic te_prev;
  logic mon_en;

  multi_clock_gate #(.N_CH(N), .IDLE_CYCLES(IDLE_A), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .test_en(test_en),
    .gated_clk(gated_a), .ch_on(ch_on_a), .all_off(all_off_a)
  );

  multi_clock_gate #(.N_CH(N), .IDLE_CYCLES(IDLE_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .test_en(test_en),
    .gated_clk(gated_b), .ch_on(ch_on_b), .all_off(all_off_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forget all enable history (after a reset).
  task automatic model_clear;
    p       = 0;
    te_prev = 1'b0;
    for (int i = 0; i < N; i++) last_hi[i] = -1000;
  endtask

  // One clock: drive inputs, predict the high phase after the posedge, compare.
  // A branch pulses at posedge p if test_en was sampled high at p-1, or its
  // enable was sampled high anywhere in posedges p-1-IDLE .. p-1.
  task automatic cycle(input logic [N-1:0] en, input logic te);
    logic [N-1:0] exp_a, exp_b;
    enable  = en;
    test_en = te;
    @(posedge clk);
    p++;
    for (int i = 0; i < N; i++) begin
      exp_a[i] = te_prev || (last_hi[i] >= p - 1 - IDLE_A);
      exp_b[i] = te_prev || (last_hi[i] >= p - 1 - IDLE_B);
    end
    for (int i = 0; i < N; i++) if (en[i]) last_hi[i] = p;
    te_prev = te;
    #1;
    vectors++;
    if (gated_a !== exp_a) begin
      errors++; $display("FAIL gated_a cycle %0d: got %b expected %b", p, gated_a, exp_a);
    end
    vectors++;
    if (ch_on_a !== exp_a) begin
      errors++; $display("FAIL ch_on_a cycle %0d: got %b expected %b", p, ch_on_a, exp_a);
    end
    vectors++;
    if (all_off_a !== ~|exp_a) begin
      errors++; $display("FAIL all_off_a cycle %0d: got %b expected %b", p, all_off_a, ~|exp_a);
    end
    vectors++;
    if (gated_b !== exp_b) begin
      errors++; $display("FAIL gated_b cycle %0d: got %b expected %b", p, gated_b, exp_b);
    end
    vectors++;
    if (ch_on_b !== exp_b) begin
      errors++; $display("FAIL ch_on_b cycle %0d: got %b expected %b", p, ch_on_b, exp_b);
    end
    vectors++;
    if (all_off_b !== ~|exp_b) begin
      errors++; $display("FAIL all_off_b cycle %0d: got %b expected %b", p, all_off_b, ~|exp_b);
    end
  endtask

  task automatic drain;
    repeat (12) cycle('0, 1'b0);
  endtask

  task automatic test_reset;
    enable  = '1;
    test_en = 1'b0;
    reset   = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      vectors++;
      if (gated_a !== '0 || gated_b !== '0) begin
        errors++; $display("FAIL reset_high_phase: got %b/%b expected 0000/0000", gated_a, gated_b);
      end
      vectors++;
      if (ch_on_a !== '0 || ch_on_b !== '0 || all_off_a !== 1'b1 || all_off_b !== 1'b1) begin
        errors++; $display("FAIL reset_status: ch_on %b/%b all_off %b/%b expected 0000/0000 1/1",
                           ch_on_a, ch_on_b, all_off_a, all_off_b);
      end
      @(negedge clk); #1;
      vectors++;
      if (gated_a !== '0 || gated_b !== '0) begin
        errors++; $display("FAIL reset_low_phase: got %b/%b expected 0000/0000", gated_a, gated_b);
      end
    end
    // Release in the middle of a high phase: no runt pulse allowed.
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (gated_a !== '0 || gated_b !== '0) begin
      errors++; $display("FAIL release_runt: got %b/%b expected 0000/0000", gated_a, gated_b);
    end
    @(negedge clk); #1;
    vectors++;
    if (ch_on_a !== '0 || all_off_a !== 1'b1 || ch_on_b !== '0 || all_off_b !== 1'b1) begin
      errors++; $display("FAIL release_status: ch_on %b/%b all_off %b/%b expected 0000/0000 1/1",
                         ch_on_a, ch_on_b, all_off_a, all_off_b);
    end
    model_clear();
    repeat (4) cycle('1, 1'b0);
    drain();
  endtask

  task automatic test_turn_on_off;
    int pulses = 0;
    for (int c = 1; c <= 35; c++) begin
      cycle((c >= 10 && c <= 19) ? 4'b0001 : 4'b0000, 1'b0);
      if (gated_a[0]) pulses++;
    end
    vectors++;
    if (pulses !== 18) begin
      errors++; $display("FAIL turn_off_pulse_count: got %0d expected 18", pulses);
    end
  endtask

  task automatic test_hysteresis;
    int pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      cycle((c <= 4 || (c >= 9 && c <= 20)) ? 4'b0010 : 4'b0000, 1'b0);
      if (c >= 2 && c <= 20 && gated_a[1]) pulses++;
    end
    vectors++;
    if (pulses !== 19) begin
      errors++; $display("FAIL hysteresis_no_gap: got %0d pulses expected 19", pulses);
    end
  endtask

  task automatic test_idle_zero;
    for (int c = 1; c <= 10; c++) begin
      cycle((c <= 6) ? 4'b0100 : 4'b0000, 1'b0);
      if (c == 7) begin
        vectors++;
        if (gated_b[2] !== 1'b1) begin
          errors++; $display("FAIL idle0_last_pulse: got %b expected 1", gated_b[2]);
        end
      end
      if (c == 8) begin
        vectors++;
        if (gated_b[2] !== 1'b0) begin
          errors++; $display("FAIL idle0_suppressed: got %b expected 0", gated_b[2]);
        end
      end
    end
    drain();
  endtask

  task automatic test_test_en;
    int pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      cycle('0, (c >= 3 && c <= 11));
      pulses += $countones(gated_a);
    end
    vectors++;
    if (pulses !== 36) begin
      errors++; $display("FAIL test_en_pulse_count: got %0d expected 36", pulses);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] en = '0;
    logic         te = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) en[i] = ~en[i];
      if ($urandom_range(0, 19) == 0) te = ~te;
      cycle(en, te);
    end
    drain();
  endtask

  // Waveform-shape monitor: high phases are never cut short and low phases stay low.
  always begin : glitch_mon
    logic [N-1:0] ha, hb;
    @(posedge clk); #1;
    ha = gated_a;
    hb = gated_b;
    #3;
    if (mon_en && reset) begin
      vectors++;
      if (ha !== gated_a || hb !== gated_b) begin
        errors++; $display("FAIL glitch_high_phase t=%0t: got %b/%b expected %b/%b",
                           $time, gated_a, gated_b, ha, hb);
      end
    end
    @(negedge clk); #1;
    if (mon_en && reset) begin
      vectors++;
      if (gated_a !== '0 || gated_b !== '0) begin
        errors++; $display("FAIL glitch_low_phase t=%0t: got %b/%b expected 0000/0000",
                           $time, gated_a, gated_b);
      end
    end
    #3;
    if (mon_en && reset) begin
      vectors++;
      if (gated_a !== '0 || gated_b !== '0) begin
        errors++; $display("FAIL glitch_late_low t=%0t: got %b/%b expected 0000/0000",
                           $time, gated_a, gated_b);
      end
    end
  end

  initial begin
    vectors = 0;
    errors  = 0;
    mon_en  = 1'b0;
    reset   = 1'b0;
    enable  = '0;
    test_en = 1'b0;
    model_clear();
    test_reset();
    mon_en = 1'b1;
    test_turn_on_off();
    test_hysteresis();
    test_idle_zero();
    test_test_en();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
